// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
// Shared definitions for the pacman scoring path: game-phase encoding, the
// binary score width and the default point values. The phase encoding is
// also used by anything that decodes the phase output.
// ---------------------------------------------------------------------------
package score_pkg;

  localparam int SCORE_W = 9;

  localparam int DEF_PELLET_PTS   = 1;
  localparam int DEF_POWER_PTS    = 5;
  localparam int DEF_GHOST_BASE   = 2;
  localparam int DEF_POWER_CYCLES = 500;
  localparam int DEF_SCORE_MAX    = 511;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    POWER = 2'd2,
    OVER  = 2'd3
  } phase_e;

  // Ghost value doubles with each ghost already eaten in this power period:
  // base, 2*base, 4*base, 8*base. The combo counter saturates at 3, so the
  // fourth and later ghosts all score 8*base.
  function automatic logic [SCORE_W-1:0] ghost_points(input logic [1:0] combo,
                                                      input int         base);
    logic [SCORE_W-1:0] b;
    b = SCORE_W'(base);
    return b << combo;
  endfunction

endpackage

// File: rtl/sat_adder.sv
// ---------------------------------------------------------------------------
// sat_adder
// Combinational add-and-clamp. The sum is formed one bit wider than the
// operands so it cannot wrap, then limited to MAX.
//
// Ports:
//   i_a   [WIDTH-1:0]  first operand
//   i_b   [WIDTH-1:0]  second operand
//   o_sum [WIDTH-1:0]  min(i_a + i_b, MAX)
// ---------------------------------------------------------------------------
module sat_adder #(
  parameter int WIDTH = 9,
  parameter int MAX   = 511
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MAX);

  logic [WIDTH:0] w_raw;

  assign w_raw = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum = (w_raw > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : w_raw[WIDTH-1:0];

endmodule

// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
// Turns one-cycle gameplay event pulses into a saturating binary score,
// keeps the best completed-game score, and runs the game-phase FSM with the
// power-pellet timer and ghost combo counter. All outputs are registered.
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   game_start    pulse: start (or restart) a game
//   pellet_eaten  pulse: normal pellet
//   power_eaten   pulse: power pellet
//   ghost_eaten   pulse: ghost eaten (only scores while powered)
//   player_dead   pulse: game over
//   score         [8:0] current score, to the BCD converter
//   high_score    [8:0] best completed-game score
//   powered       high while in POWER
//   combo         [1:0] ghosts eaten this power period, saturates at 3
//   new_high      one-cycle pulse aligned with a high_score update
//   phase         [1:0] IDLE=0, PLAY=1, POWER=2, OVER=3
// ---------------------------------------------------------------------------
module score_keeper
  import score_pkg::*;
#(
  parameter int PELLET_PTS   = DEF_PELLET_PTS,
  parameter int POWER_PTS    = DEF_POWER_PTS,
  parameter int GHOST_BASE   = DEF_GHOST_BASE,
  parameter int POWER_CYCLES = DEF_POWER_CYCLES,
  parameter int SCORE_MAX    = DEF_SCORE_MAX
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               game_start,
  input  logic               pellet_eaten,
  input  logic               power_eaten,
  input  logic               ghost_eaten,
  input  logic               player_dead,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               powered,
  output logic [1:0]         combo,
  output logic               new_high,
  output logic [1:0]         phase
);

  localparam int               TMR_W    = $clog2(POWER_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(POWER_CYCLES - 1);

  phase_e             r_phase;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_high;
  logic [TMR_W-1:0]   r_timer;
  logic [1:0]         r_combo;
  logic               r_powered;
  logic               r_new_high;

  logic [SCORE_W-1:0] w_pts;
  logic [SCORE_W-1:0] w_score_sum;
  logic [1:0]         w_combo_next;

  // Points from every event in this cycle are summed before the clamp, so
  // simultaneous events saturate together. Ghosts only count while powered
  // and are valued from the combo held before this edge.
  always_comb begin
    // NOTE: default first so every path assigns w_pts and no latch is inferred.
    w_pts = '0;
    if (pellet_eaten) w_pts = w_pts + SCORE_W'(PELLET_PTS);
    if (power_eaten)  w_pts = w_pts + SCORE_W'(POWER_PTS);
    if (ghost_eaten && (r_phase == POWER))
      w_pts = w_pts + ghost_points(r_combo, GHOST_BASE);
  end

  assign w_combo_next = (ghost_eaten && (r_combo != 2'd3)) ? r_combo + 2'd1 : r_combo;

  sat_adder #(
    .WIDTH (SCORE_W),
    .MAX   (SCORE_MAX)
  ) u_sat_adder (
    .i_a   (r_score),
    .i_b   (w_pts),
    .o_sum (w_score_sum)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase    <= IDLE;
      r_score    <= '0;
      r_high     <= '0;
      r_timer    <= '0;
      r_combo    <= '0;
      r_powered  <= 1'b0;
      r_new_high <= 1'b0;
    end else begin
      r_new_high <= 1'b0;

      unique case (r_phase)
        IDLE: begin
          if (game_start) begin
            r_phase <= PLAY;
            r_score <= '0;
          end
        end

        PLAY: begin
          if (game_start) begin
            r_phase <= PLAY;
            r_score <= '0;
            r_combo <= '0;
            r_timer <= '0;
          end else if (player_dead) begin
            // Same-cycle events are discarded; the score as it stands is final.
            r_phase <= OVER;
            r_combo <= '0;
            r_timer <= '0;
            if (r_score > r_high) begin
              r_high     <= r_score;
              r_new_high <= 1'b1;
            end
          end else begin
            r_score <= w_score_sum;
            if (power_eaten) begin
              r_phase   <= POWER;
              r_timer   <= TMR_LOAD;
              r_powered <= 1'b1;
            end
          end
        end

        POWER: begin
          if (game_start) begin
            r_phase   <= PLAY;
            r_score   <= '0;
            r_combo   <= '0;
            r_timer   <= '0;
            r_powered <= 1'b0;
          end else if (player_dead) begin
            r_phase   <= OVER;
            r_combo   <= '0;
            r_timer   <= '0;
            r_powered <= 1'b0;
            if (r_score > r_high) begin
              r_high     <= r_score;
              r_new_high <= 1'b1;
            end
          end else begin
            r_score <= w_score_sum;
            if (power_eaten) begin
              // A fresh power pellet extends the period but keeps the combo.
              r_timer <= TMR_LOAD;
              r_combo <= w_combo_next;
            end else if (r_timer == '0) begin
              // Timer loaded with POWER_CYCLES-1 and counted down to 0, so
              // POWER has been visible for exactly POWER_CYCLES cycles.
              r_phase   <= PLAY;
              r_powered <= 1'b0;
              r_combo   <= '0;
            end else begin
              r_timer <= r_timer - 1'b1;
              r_combo <= w_combo_next;
            end
          end
        end

        OVER: begin
          if (game_start) begin
            r_phase <= PLAY;
            r_score <= '0;
          end
        end

        default: r_phase <= IDLE;
      endcase
    end
  end

  assign score      = r_score;
  assign high_score = r_high;
  assign powered    = r_powered;
  assign combo      = r_combo;
  assign new_high   = r_new_high;
  assign phase      = r_phase;

endmodule

// File: tb/tb_score_keeper.sv
// ---------------------------------------------------------------------------
// tb_score_keeper
// Directed bench for score_keeper with default parameters (POWER_CYCLES=500).
// Inputs change 1 time unit after a rising edge and are held for one cycle;
// outputs are sampled at the same point, after the edge has settled.
// ---------------------------------------------------------------------------
module tb_score_keeper;

  logic       clk;
  logic       reset_n;
  logic       game_start;
  logic       pellet_eaten;
  logic       power_eaten;
  logic       ghost_eaten;
  logic       player_dead;
  logic [8:0] score;
  logic [8:0] high_score;
  logic       powered;
  logic [1:0] combo;
  logic       new_high;
  logic [1:0] phase;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_PLAY  = 2'd1;
  localparam logic [1:0] P_POWER = 2'd2;
  localparam logic [1:0] P_OVER  = 2'd3;

  score_keeper dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .game_start   (game_start),
    .pellet_eaten (pellet_eaten),
    .power_eaten  (power_eaten),
    .ghost_eaten  (ghost_eaten),
    .player_dead  (player_dead),
    .score        (score),
    .high_score   (high_score),
    .powered      (powered),
    .combo        (combo),
    .new_high     (new_high),
    .phase        (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then drop all event pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    game_start   = 1'b0;
    pellet_eaten = 1'b0;
    power_eaten  = 1'b0;
    ghost_eaten  = 1'b0;
    player_dead  = 1'b0;
  endtask

  task automatic pellets(input int n);
    repeat (n) begin
      pellet_eaten = 1'b1;
      tick();
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    game_start   = 1'b0;
    pellet_eaten = 1'b0;
    power_eaten  = 1'b0;
    ghost_eaten  = 1'b0;
    player_dead  = 1'b0;

    // Reset state
    #2;
    check("rst_score", score, 0);
    check("rst_high", high_score, 0);
    check("rst_powered", powered, 0);
    check("rst_combo", combo, 0);
    check("rst_new_high", new_high, 0);
    check("rst_phase", phase, P_IDLE);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // IDLE ignores everything but game_start
    pellet_eaten = 1'b1;
    player_dead  = 1'b1;
    tick();
    check("idle_ignore_score", score, 0);
    check("idle_ignore_phase", phase, P_IDLE);

    // Game 1: start, 3 pellets, power pellet
    game_start = 1'b1;
    tick();
    check("start_phase", phase, P_PLAY);
    check("start_score", score, 0);
    pellets(3);
    check("three_pellets", score, 3);
    power_eaten = 1'b1;
    tick();
    check("power_score", score, 8);
    check("power_phase", phase, P_POWER);
    check("power_powered", powered, 1);
    check("power_combo", combo, 0);

    // POWER lasts exactly 500 cycles
    repeat (499) tick();
    check("power_last_cycle", phase, P_POWER);
    tick();
    check("power_expired_phase", phase, P_PLAY);
    check("power_expired_powered", powered, 0);

    // Ghost in PLAY is not edible
    ghost_eaten = 1'b1;
    tick();
    check("play_ghost_ignored", score, 8);

    // Ghost combo chain: 2,4,8,16,16
    power_eaten = 1'b1;
    tick();
    check("power2_score", score, 13);
    ghost_eaten = 1'b1; tick();
    check("ghost1_score", score, 15);
    check("ghost1_combo", combo, 1);
    ghost_eaten = 1'b1; tick();
    check("ghost2_score", score, 19);
    check("ghost2_combo", combo, 2);
    ghost_eaten = 1'b1; tick();
    check("ghost3_score", score, 27);
    check("ghost3_combo", combo, 3);
    ghost_eaten = 1'b1; tick();
    check("ghost4_score", score, 43);
    check("ghost4_combo", combo, 3);
    ghost_eaten = 1'b1; tick();
    check("ghost5_score", score, 59);
    check("ghost5_combo", combo, 3);

    // Timer now at 494; run to 2 (three cycles left), then reload
    repeat (492) tick();
    check("near_end_phase", phase, P_POWER);
    power_eaten = 1'b1;
    tick();
    check("reload_score", score, 64);
    check("reload_combo", combo, 3);
    repeat (499) tick();
    check("reload_still_power", phase, P_POWER);
    check("reload_combo_kept", combo, 3);
    tick();
    check("reload_expired_phase", phase, P_PLAY);
    check("reload_expired_combo", combo, 0);

    // Finish game 1 at 120; death with a same-cycle pellet
    pellets(56);
    check("g1_score", score, 120);
    player_dead  = 1'b1;
    pellet_eaten = 1'b1;
    tick();
    check("g1_over_phase", phase, P_OVER);
    check("g1_over_score", score, 120);
    check("g1_high", high_score, 120);
    check("g1_new_high", new_high, 1);
    pellet_eaten = 1'b1;
    player_dead  = 1'b1;
    tick();
    check("g1_new_high_drop", new_high, 0);
    check("over_hold_score", score, 120);
    check("over_hold_phase", phase, P_OVER);

    // Game 2 ties at 120: no update
    game_start = 1'b1;
    tick();
    check("g2_start_score", score, 0);
    check("g2_high_kept", high_score, 120);
    pellets(120);
    player_dead = 1'b1;
    tick();
    check("g2_high", high_score, 120);
    check("g2_new_high", new_high, 0);

    // Game 3 beats it with 121
    game_start = 1'b1;
    tick();
    pellets(121);
    player_dead = 1'b1;
    tick();
    check("g3_high", high_score, 121);
    check("g3_new_high", new_high, 1);
    tick();
    check("g3_new_high_drop", new_high, 0);

    // Restart mid-POWER
    game_start = 1'b1;
    tick();
    power_eaten = 1'b1;
    tick();
    ghost_eaten = 1'b1;
    tick();
    check("restart_pre_score", score, 7);
    check("restart_pre_combo", combo, 1);
    game_start = 1'b1;
    tick();
    check("restart_phase", phase, P_PLAY);
    check("restart_score", score, 0);
    check("restart_combo", combo, 0);
    check("restart_powered", powered, 0);
    check("restart_high", high_score, 121);

    // Saturation: 504 in PLAY, power -> 509 in POWER with combo 0
    pellets(504);
    power_eaten = 1'b1;
    tick();
    check("sat_pre_score", score, 509);
    pellet_eaten = 1'b1;
    power_eaten  = 1'b1;
    ghost_eaten  = 1'b1;
    tick();
    check("sat_clamp", score, 511);
    check("sat_combo", combo, 1);
    pellets(3);
    check("sat_hold", score, 511);

    // Asynchronous reset mid-POWER with score 37
    game_start = 1'b1;
    tick();
    pellets(32);
    power_eaten = 1'b1;
    tick();
    check("pre_reset_score", score, 37);
    check("pre_reset_phase", phase, P_POWER);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_score", score, 0);
    check("async_rst_phase", phase, P_IDLE);
    check("async_rst_powered", powered, 0);
    check("async_rst_high", high_score, 0);
    check("async_rst_combo", combo, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
